// File: rtl/register_bank_if.sv
// Register bank access bus: one write port plus two independent read ports.
// Latency: read data is registered and appears one clock after an enabled read.
// Backpressure: none; every strobe is accepted on the edge at which it is sampled.
interface register_bank_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 4
);
  logic                  write_en;
  logic [ADDR_WIDTH-1:0] write_addr;
  logic [DATA_WIDTH-1:0] write_data;
  logic                  read_en_a;
  logic [ADDR_WIDTH-1:0] read_addr_a;
  logic [DATA_WIDTH-1:0] read_data_a;
  logic                  read_en_b;
  logic [ADDR_WIDTH-1:0] read_addr_b;
  logic [DATA_WIDTH-1:0] read_data_b;

  // Requester side: drives strobes, addresses and write data.
  modport master (
    output write_en, write_addr, write_data,
    output read_en_a, read_addr_a,
    output read_en_b, read_addr_b,
    input  read_data_a, read_data_b
  );

  // Register bank side: returns registered read data.
  modport slave (
    input  write_en, write_addr, write_data,
    input  read_en_a, read_addr_a,
    input  read_en_b, read_addr_b,
    output read_data_a, read_data_b
  );
endinterface

// File: rtl/register_bank.sv
// General-purpose register file: NUM_REGS words, one write port, two registered read ports.
// Latency: a read enabled at edge N presents its data right after edge N (one cycle).
// Backpressure: none; writes and reads are accepted unconditionally every cycle.
module register_bank #(
  parameter int                    DATA_WIDTH = 32,
  parameter int                    NUM_REGS   = 16,
  parameter int                    ADDR_WIDTH = 4,
  parameter logic [DATA_WIDTH-1:0] INIT       = '0,
  parameter bit                    ZERO_REG0  = 1'b0,
  parameter bit                    BYPASS     = 1'b1
) (
  input logic            clock,
  input logic            clear,
  register_bank_if.slave bus
);

  // One extra bit so NUM_REGS == 2**ADDR_WIDTH is representable; the full
  // address is compared against it so unused high codes never alias a register.
  localparam logic [ADDR_WIDTH:0] LIMIT = NUM_REGS[ADDR_WIDTH:0];

  function automatic logic in_range(input logic [ADDR_WIDTH-1:0] addr);
    return ({1'b0, addr} < LIMIT);
  endfunction

  // Power-up contents are a simulation convenience; clear is the real reset.
  logic [DATA_WIDTH-1:0] regs [NUM_REGS] = '{default: INIT};
  logic [DATA_WIDTH-1:0] data_a = INIT;
  logic [DATA_WIDTH-1:0] data_b = INIT;

  logic                  write_ok;
  logic [DATA_WIDTH-1:0] next_a;
  logic [DATA_WIDTH-1:0] next_b;

  // A write lands only for an in-range address, and never into a hardwired R0.
  assign write_ok = bus.write_en
                 && in_range(bus.write_addr)
                 && !(ZERO_REG0 && (bus.write_addr == '0));

  // Register array update; clear wins over any write in the same cycle.
  always_ff @(posedge clock) begin
    if (clear) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs[i] <= '0;
      end
    end else if (write_ok) begin
      regs[bus.write_addr] <= bus.write_data;
    end
  end

  // Read-port selection: out-of-range and hardwired R0 give zero; with BYPASS a
  // same-cycle write to the read address is forwarded (write-first).
  always_comb begin
    next_a = '0;
    next_b = '0;
    if (in_range(bus.read_addr_a) && !(ZERO_REG0 && (bus.read_addr_a == '0))) begin
      next_a = regs[bus.read_addr_a];
      if (BYPASS && write_ok && (bus.write_addr == bus.read_addr_a)) begin
        next_a = bus.write_data;
      end
    end
    if (in_range(bus.read_addr_b) && !(ZERO_REG0 && (bus.read_addr_b == '0))) begin
      next_b = regs[bus.read_addr_b];
      if (BYPASS && write_ok && (bus.write_addr == bus.read_addr_b)) begin
        next_b = bus.write_data;
      end
    end
  end

  // Port A output register: loads on its strobe, otherwise holds.
  always_ff @(posedge clock) begin
    if (clear) begin
      data_a <= '0;
    end else if (bus.read_en_a) begin
      data_a <= next_a;
    end
  end

  // Port B output register: loads on its strobe, otherwise holds.
  always_ff @(posedge clock) begin
    if (clear) begin
      data_b <= '0;
    end else if (bus.read_en_b) begin
      data_b <= next_b;
    end
  end

  assign bus.read_data_a = data_a;
  assign bus.read_data_b = data_b;

endmodule

// File: tb/tb_register_bank.sv
// Bench for register_bank: three configurations driven by one shared stimulus stream.
// Latency: outputs checked 1 time unit after each rising edge against a reference model.
// Backpressure: not applicable; one transaction per clock.
module tb_register_bank;
  localparam int DW   = 32;
  localparam int AW   = 4;
  localparam int NCFG = 3;

  logic          clock;
  logic          clear;
  logic          write_en;
  logic [AW-1:0] write_addr;
  logic [DW-1:0] write_data;
  logic          read_en_a;
  logic [AW-1:0] read_addr_a;
  logic          read_en_b;
  logic [AW-1:0] read_addr_b;
  logic [DW-1:0] rda [NCFG];
  logic [DW-1:0] rdb [NCFG];

  int checks = 0;
  int errors = 0;

  // Configuration table: 0 = 16 regs, write-first, no R0;
  // 1 = 12 regs, read-first, R0 hardwired; 2 = 12 regs, write-first, R0 hardwired.
  function automatic int cfg_regs(input int c);
    return (c == 0) ? 16 : 12;
  endfunction
  function automatic bit cfg_bypass(input int c);
    return (c != 1);
  endfunction
  function automatic bit cfg_zero(input int c);
    return (c != 0);
  endfunction

  for (genvar g = 0; g < NCFG; g++) begin : cfg
    register_bank_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();
    assign bus.write_en    = write_en;
    assign bus.write_addr  = write_addr;
    assign bus.write_data  = write_data;
    assign bus.read_en_a   = read_en_a;
    assign bus.read_addr_a = read_addr_a;
    assign bus.read_en_b   = read_en_b;
    assign bus.read_addr_b = read_addr_b;
    assign rda[g] = bus.read_data_a;
    assign rdb[g] = bus.read_data_b;

    register_bank #(
      .DATA_WIDTH (DW),
      .NUM_REGS   ((g == 0) ? 16 : 12),
      .ADDR_WIDTH (AW),
      .INIT       ('0),
      .ZERO_REG0  (g != 0),
      .BYPASS     (g != 1)
    ) dut (
      .clock (clock),
      .clear (clear),
      .bus   (bus.slave)
    );
  end

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Reference model: register contents and expected outputs per configuration.
  logic [DW-1:0] mem   [NCFG][16];
  logic [DW-1:0] exp_a [NCFG];
  logic [DW-1:0] exp_b [NCFG];

  // Apply one clock edge to the model. Write-first reads see the post-write
  // array, read-first reads see the pre-write copy.
  task automatic model_edge();
    logic [DW-1:0] old [16];
    for (int c = 0; c < NCFG; c++) begin
      if (clear) begin
        for (int i = 0; i < 16; i++) mem[c][i] = '0;
        exp_a[c] = '0;
        exp_b[c] = '0;
      end else begin
        for (int i = 0; i < 16; i++) old[i] = mem[c][i];
        if (write_en && int'(write_addr) < cfg_regs(c) && !(cfg_zero(c) && write_addr == '0))
          mem[c][write_addr] = write_data;
        if (read_en_a)
          exp_a[c] = (int'(read_addr_a) >= cfg_regs(c)) ? '0 :
                     cfg_bypass(c) ? mem[c][read_addr_a] : old[read_addr_a];
        if (read_en_b)
          exp_b[c] = (int'(read_addr_b) >= cfg_regs(c)) ? '0 :
                     cfg_bypass(c) ? mem[c][read_addr_b] : old[read_addr_b];
      end
    end
  endtask

  task automatic check(input string tag);
    for (int c = 0; c < NCFG; c++) begin
      checks++;
      assert (rda[c] === exp_a[c]) else begin
        errors++;
        $error("FAIL %s cfg%0d read_data_a got %h expected %h", tag, c, rda[c], exp_a[c]);
      end
      checks++;
      assert (rdb[c] === exp_b[c]) else begin
        errors++;
        $error("FAIL %s cfg%0d read_data_b got %h expected %h", tag, c, rdb[c], exp_b[c]);
      end
    end
  endtask

  // Fixed anchor values taken straight from the intended behaviour.
  task automatic expect_const(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] want);
    checks++;
    assert (got === want) else begin
      errors++;
      $error("FAIL %s got %h expected %h", tag, got, want);
    end
  endtask

  task automatic step(input string tag, input logic clr, input logic we,
                      input logic [AW-1:0] wa, input logic [DW-1:0] wd,
                      input logic rea, input logic [AW-1:0] ra,
                      input logic reb, input logic [AW-1:0] rb);
    clear       = clr;
    write_en    = we;
    write_addr  = wa;
    write_data  = wd;
    read_en_a   = rea;
    read_addr_a = ra;
    read_en_b   = reb;
    read_addr_b = rb;
    @(posedge clock);
    model_edge();
    #1;
    check(tag);
  endtask

  initial begin
    clear = 1'b1; write_en = 1'b0; write_addr = '0; write_data = '0;
    read_en_a = 1'b0; read_addr_a = '0; read_en_b = 1'b0; read_addr_b = '0;
    #1;

    // Reset state
    step("reset",        1, 0, 0, 0,            0, 0, 0, 0);
    expect_const("reset_a0", rda[0], 32'h0);
    step("wr_r3",        0, 1, 3, 32'hDEADBEEF, 0, 0, 0, 0);
    step("clear_pulse",  1, 0, 0, 0,            0, 0, 0, 0);
    step("rd_r3_clr",    0, 0, 0, 0,            1, 3, 0, 0);
    expect_const("rd_r3_zero", rda[0], 32'h0);

    // Basic write then read, then hold
    step("wr_r5",        0, 1, 5, 32'h12345678, 0, 0, 0, 0);
    step("rd_r5",        0, 0, 0, 0,            1, 5, 0, 0);
    expect_const("rd_r5_val", rda[1], 32'h12345678);
    step("hold",         0, 0, 0, 0,            0, 7, 0, 7);
    expect_const("hold_val", rda[2], 32'h12345678);

    // Same-edge write and dual read of one address
    step("wr_r9",        0, 1, 9, 32'h11111111, 0, 0, 0, 0);
    step("bypass",       0, 1, 9, 32'h22222222, 1, 9, 1, 9);
    expect_const("bypass_wf_a", rda[0], 32'h22222222);
    expect_const("bypass_wf_b", rdb[2], 32'h22222222);
    expect_const("bypass_rf_a", rda[1], 32'h11111111);
    expect_const("bypass_rf_b", rdb[1], 32'h11111111);
    step("reread_r9",    0, 0, 0, 0,            1, 9, 1, 9);
    expect_const("reread_rf", rda[1], 32'h22222222);

    // Clear priority over write and read
    step("clr_prio",     1, 1, 2, 32'hFF,       1, 2, 0, 0);
    expect_const("clr_prio_a", rda[0], 32'h0);
    step("rd_r2",        0, 0, 0, 0,            1, 2, 1, 2);

    // Hardwired R0
    step("wr_rd_r0",     0, 1, 0, 32'hAAAA5555, 1, 0, 0, 0);
    expect_const("r0_plain", rda[0], 32'hAAAA5555);
    expect_const("r0_zero_rf", rda[1], 32'h0);
    expect_const("r0_zero_wf", rda[2], 32'h0);
    step("rd_r0",        0, 0, 0, 0,            1, 0, 1, 0);

    // Out-of-range write/read, then full sweep
    step("oor",          0, 1, 13, 32'h5A5A5A5A, 0, 0, 1, 13);
    expect_const("oor_b_12", rdb[1], 32'h0);
    expect_const("oor_b_16", rdb[0], 32'h5A5A5A5A);
    for (int i = 0; i < 16; i++)
      step("sweep", 0, 0, 0, 0, 1, AW'(i), 1, AW'(15 - i));

    // Random traffic against the model
    for (int n = 0; n < 800; n++)
      step("random", ($urandom_range(0, 31) == 0), 1'($urandom_range(0, 1)),
           AW'($urandom_range(0, 15)), $urandom,
           1'($urandom_range(0, 1)), AW'($urandom_range(0, 15)),
           1'($urandom_range(0, 1)), AW'($urandom_range(0, 15)));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
